mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory bus between instruction fetch (IF) and the MEM stage
//  (driven from the EX/MEM pipeline register: address, store data, byteenable, opcode).

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/arb_wait_timer.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
// Holds the FSM state encoding, the fetch lane mask and a counter-width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StBusyIf = 2'b01,
        StBusyDm = 2'b10
    } arb_state_e;

    localparam logic [3:0] FetchBe = 4'b1111;

    // Width needed to count up to max_val inclusive, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Counts bus wait cycles of the current access and flags the cycle in which
// the wait count reaches TIMEOUT, so the arbiter can abort in that same edge.
module arb_wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CntW = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntMax   = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] LastWait = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CntMax)) begin
            count_d = count_q + 1'b1;
        end
    end

    // This wait cycle is the one that brings the count to TIMEOUT.
    assign expired_o = inc_i && (count_q == LastWait);

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the MEM stage,
// with DM priority, IF anti-starvation, registered bus outputs and a wait timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [3:0]  dm_byteenable_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ready_o,
    output logic        stall_if_o,
    output logic        stall_mem_o,
    output logic        bus_valid_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_byteenable_o,
    input  logic        bus_ready_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_error_o
);

    localparam int unsigned StreakW = cnt_width(STARVE_LIMIT);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              bus_error_q, bus_error_d;
    logic [StreakW-1:0] streak_q, streak_d;

    logic grant_if, grant_dm, starve, done, wait_cycle, expired;

    assign done       = bus_valid_q && bus_ready_i;
    assign wait_cycle = bus_valid_q && !bus_ready_i;
    assign starve     = (STARVE_LIMIT != 0) && (streak_q == StreakMax);

    arb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (grant_if || grant_dm),
        .inc_i     (wait_cycle),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        bus_error_d = bus_error_q;
        streak_d    = streak_q;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dm_req_i && !(if_req_i && starve)) begin
                    grant_dm = 1'b1;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                end
            end
            StBusyIf: begin
                if (done) begin
                    if_rdata_d  = bus_rdata_i;
                    if_ready_d  = 1'b1;
                    bus_valid_d = 1'b0;
                    state_d     = StIdle;
                end else if (expired) begin
                    if_rdata_d  = '0;
                    if_ready_d  = 1'b1;
                    bus_valid_d = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StBusyDm: begin
                if (done) begin
                    if (!bus_we_q) begin
                        dm_rdata_d = bus_rdata_i;
                    end
                    dm_ready_d  = 1'b1;
                    bus_valid_d = 1'b0;
                    state_d     = StIdle;
                end else if (expired) begin
                    dm_rdata_d  = '0;
                    dm_ready_d  = 1'b1;
                    bus_valid_d = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                bus_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase

        if (grant_dm) begin
            bus_valid_d = 1'b1;
            bus_we_d    = dm_we_i;
            bus_addr_d  = dm_addr_i;
            bus_wdata_d = dm_wdata_i;
            bus_be_d    = dm_byteenable_i;
            state_d     = StBusyDm;
            // Only DM wins taken while IF is waiting count toward starvation.
            if (if_req_i && (streak_q != StreakMax)) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (grant_if) begin
            bus_valid_d = 1'b1;
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr_i;
            bus_wdata_d = '0;
            bus_be_d    = FetchBe;
            state_d     = StBusyIf;
            streak_d    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            bus_error_q <= 1'b0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            bus_error_q <= bus_error_d;
            streak_q    <= streak_d;
        end
    end

    assign if_rdata_o       = if_rdata_q;
    assign if_ready_o       = if_ready_q;
    assign dm_rdata_o       = dm_rdata_q;
    assign dm_ready_o       = dm_ready_q;
    assign stall_if_o       = if_req_i && !if_ready_q;
    assign stall_mem_o      = dm_req_i && !dm_ready_q;
    assign bus_valid_o      = bus_valid_q;
    assign bus_we_o         = bus_we_q;
    assign bus_addr_o       = bus_addr_q;
    assign bus_wdata_o      = bus_wdata_q;
    assign bus_byteenable_o = bus_be_q;
    assign bus_error_o      = bus_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions, all judged against a transaction-level model of the arbiter rules.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        stall_if, stall_mem;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_error;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE),
        .TIMEOUT      (TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .if_req_i         (if_req),
        .if_addr_i        (if_addr),
        .if_rdata_o       (if_rdata),
        .if_ready_o       (if_ready),
        .dm_req_i         (dm_req),
        .dm_we_i          (dm_we),
        .dm_addr_i        (dm_addr),
        .dm_wdata_i       (dm_wdata),
        .dm_byteenable_i  (dm_be),
        .dm_rdata_o       (dm_rdata),
        .dm_ready_o       (dm_ready),
        .stall_if_o       (stall_if),
        .stall_mem_o      (stall_mem),
        .bus_valid_o      (bus_valid),
        .bus_we_o         (bus_we),
        .bus_addr_o       (bus_addr),
        .bus_wdata_o      (bus_wdata),
        .bus_byteenable_o (bus_be),
        .bus_ready_i      (bus_ready),
        .bus_rdata_i      (bus_rdata),
        .bus_error_o      (bus_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what each port last returned, the sticky error, the DM-win streak.
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_dm_rdata = '0;
    logic        m_err      = 1'b0;
    int          m_streak   = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string phase);
        chk({phase, " if_rdata"}, if_rdata, 32'h0);
        chk({phase, " if_ready"}, if_ready, 32'h0);
        chk({phase, " dm_rdata"}, dm_rdata, 32'h0);
        chk({phase, " dm_ready"}, dm_ready, 32'h0);
        chk({phase, " stall_if"}, stall_if, 32'h0);
        chk({phase, " stall_mem"}, stall_mem, 32'h0);
        chk({phase, " bus_valid"}, bus_valid, 32'h0);
        chk({phase, " bus_we"}, bus_we, 32'h0);
        chk({phase, " bus_addr"}, bus_addr, 32'h0);
        chk({phase, " bus_wdata"}, bus_wdata, 32'h0);
        chk({phase, " bus_be"}, bus_be, 32'h0);
        chk({phase, " bus_error"}, bus_error, 32'h0);
    endtask

    // Who wins the bus given current requests: DM first unless IF has been passed over
    // STARVE times in a row.
    function automatic bit pick_if();
        if (dm_req && !(if_req && (STARVE != 0) && (m_streak == STARVE))) return 1'b0;
        return 1'b1;
    endfunction

    // Act as bus slave for one access: ready after lat wait cycles (lat >= TMO times out).
    task automatic serve(input int lat, input logic [31:0] rd, input bit drop, output bit obs_if);
        bit          is_if, timed_out;
        logic        exp_we;
        logic [31:0] exp_addr, exp_wd;
        logic [3:0]  exp_be;
        int          w;
        is_if = pick_if();
        if (is_if) m_streak = 0;
        else if (if_req && m_streak < STARVE) m_streak++;
        exp_we   = is_if ? 1'b0 : dm_we;
        exp_addr = is_if ? if_addr : dm_addr;
        exp_wd   = is_if ? 32'h0 : dm_wdata;
        exp_be   = is_if ? 4'b1111 : dm_be;
        w = 0;
        while (bus_valid !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
        chk("grant bus_valid", bus_valid, 32'h1);
        obs_if = (bus_addr == if_addr) && (bus_be == 4'b1111) && !bus_we;
        timed_out = 1'b0;
        for (int c = 0; c <= TMO; c++) begin
            if (c == TMO) begin
                timed_out = 1'b1;
                break;
            end
            chk("hold bus_valid", bus_valid, 32'h1);
            chk("hold bus_we", bus_we, exp_we);
            chk("hold bus_addr", bus_addr, exp_addr);
            chk("hold bus_wdata", bus_wdata, exp_wd);
            chk("hold bus_be", bus_be, exp_be);
            chk("hold if_ready", if_ready, 32'h0);
            chk("hold dm_ready", dm_ready, 32'h0);
            chk("hold stall_if", stall_if, if_req);
            chk("hold stall_mem", stall_mem, dm_req);
            if (c == lat) begin
                bus_ready = 1'b1;
                bus_rdata = rd;
                tick();
                bus_ready = 1'b0;
                bus_rdata = $urandom();
                break;
            end
            tick();
        end
        if (timed_out) begin
            m_err = 1'b1;
            if (is_if) m_if_rdata = '0;
            else m_dm_rdata = '0;
        end else if (is_if) begin
            m_if_rdata = rd;
        end else if (!exp_we) begin
            m_dm_rdata = rd;
        end
        chk("done bus_valid", bus_valid, 32'h0);
        chk("done if_ready", if_ready, is_if);
        chk("done dm_ready", dm_ready, !is_if);
        chk("done if_rdata", if_rdata, m_if_rdata);
        chk("done dm_rdata", dm_rdata, m_dm_rdata);
        chk("done bus_error", bus_error, m_err);
        chk("done stall_if", stall_if, if_req && !is_if);
        chk("done stall_mem", stall_mem, dm_req && is_if);
        if (drop) begin
            if (is_if) if_req = 1'b0;
            else dm_req = 1'b0;
        end
        tick();
        chk("pulse if_ready", if_ready, 32'h0);
        chk("pulse dm_ready", dm_ready, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got_if;
        bit          order[7];
        int          kind;
        logic [31:0] rd;
        bus_rdata = $urandom();

        // 1: reset, then idle for 10 cycles
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_all_zero("idle");
            tick();
        end

        // 2: single fetch, ready on first valid cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        serve(0, 32'h2402_0005, 1'b1, got_if);
        chk("fetch if_rdata", if_rdata, 32'h2402_0005);

        // 3: both held, store from MEM; expect DM x4, IF, DM, then drained IF
        if_req   = 1'b1;
        if_addr  = 32'h0000_0080;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h1000_0000;
        dm_wdata = 32'hCAFE_F00D;
        dm_be    = 4'b0011;
        for (int i = 0; i < 7; i++) begin
            serve($urandom_range(0, 3), $urandom(), (i >= 5), got_if);
            order[i] = got_if;
        end
        chk("order 0", order[0], 32'h0);
        chk("order 3", order[3], 32'h0);
        chk("order 4", order[4], 32'h1);
        chk("order 5", order[5], 32'h0);
        chk("order 6", order[6], 32'h1);

        // 4: load with ready delayed 3 cycles
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h1000_0010;
        dm_be   = 4'b1111;
        serve(3, 32'h1234_5678, 1'b1, got_if);
        chk("load dm_rdata", dm_rdata, 32'h1234_5678);

        // random phase without timeouts
        for (int t = 0; t < 20; t++) begin
            kind     = $urandom_range(0, 2);
            if_addr  = {$urandom_range(0, 32'hFFFF), 2'b00, 14'h0} | 32'h4;
            dm_addr  = $urandom() & 32'hFFFF_FFF0;
            dm_we    = $urandom_range(0, 1);
            dm_wdata = $urandom();
            dm_be    = $urandom_range(1, 15);
            if_req   = (kind != 1);
            dm_req   = (kind != 0);
            rd       = $urandom();
            serve($urandom_range(0, 5), rd, 1'b1, got_if);
            if (kind == 2) serve($urandom_range(0, 5), $urandom(), 1'b1, got_if);
        end

        // 5: load never acknowledged -> timeout
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h2000_0000;
        serve(TMO + 5, 32'hDEAD_BEEF, 1'b1, got_if);
        chk("timeout dm_rdata", dm_rdata, 32'h0);
        chk("timeout bus_error", bus_error, 32'h1);
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        serve(1, 32'h0BAD_0001, 1'b1, got_if);
        chk("sticky bus_error", bus_error, 32'h1);

        // 6: reset while DM access is pending on the bus
        dm_req  = 1'b1;
        dm_addr = 32'h3000_0000;
        tick();
        tick();
        chk("pre-reset bus_valid", bus_valid, 32'h1);
        reset  = 1'b1;
        dm_req = 1'b0;
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        m_if_rdata = '0;
        m_dm_rdata = '0;
        m_err      = 1'b0;
        m_streak   = 0;
        tick();
        chk_all_zero("post-reset");
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        serve(2, 32'h5555_AAAA, 1'b1, got_if);
        chk("post-reset if_rdata", if_rdata, 32'h5555_AAAA);

        // random phase with timeouts allowed
        for (int t = 0; t < 15; t++) begin
            kind     = $urandom_range(0, 2);
            if_addr  = {$urandom_range(0, 32'hFFFF), 2'b00, 14'h0} | 32'h8;
            dm_addr  = $urandom() & 32'hFFFF_FFF0;
            dm_we    = $urandom_range(0, 1);
            dm_wdata = $urandom();
            dm_be    = $urandom_range(1, 15);
            if_req   = (kind != 1);
            dm_req   = (kind != 0);
            serve($urandom_range(0, TMO + 1), $urandom(), 1'b1, got_if);
            if (kind == 2) serve($urandom_range(0, TMO + 1), $urandom(), 1'b1, got_if);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
